music_seq_ctrl: RTL and testbench
=================================

Name: music_seq_ctrl

Overview:
- Sequencer that walks the song ROM (synchronous BlockROM, 1-cycle read latency) word by word.
- Decodes each word into a note code and a duration, holds the note for duration × BEAT_DIV clocks, then fetches the next word.
- Sits between the CPU-facing control register (start/stop) and the tone generator that consumes note_o.

Parameters:
- ADDR_WIDTH, 8, ROM address width; must match the ROM instance.
- DATA_WIDTH, 12, ROM word width; fixed format [11:8] duration, [7:0] note; must be 12.
- BEAT_DIV, 12500000, clk cycles per duration unit; must be ≥2.
- CNT_WIDTH, 24, beat counter width; must satisfy 2^CNT_WIDTH > BEAT_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  level/pulse; starts playback from address 0 when idle
- stop_i  input  1  aborts playback immediately
- rom_addr_o  output  ADDR_WIDTH  registered address to ROM addr_i
- rom_data_i  input  DATA_WIDTH  ROM data_o
- note_o  output  8  current note code, 0 = rest/silence
- note_valid_o  output  1  high while a note word is being played
- busy_o  output  1  high in any state other than IDLE
- done_o  output  1  one-cycle pulse on normal song end

Behaviour:
- Reset (async, rst_n=0): state IDLE, rom_addr_o=0, note_o=0, note_valid_o=0, busy_o=0, done_o=0, beat/duration counters 0.
- Word format: dur=rom_data_i[11:8], note=rom_data_i[7:0]. dur=0 is the end-of-song marker; note is ignored.
- FSM states: IDLE, FETCH, DECODE, PLAY.
- IDLE:
  - start_i=1 and stop_i=0 → rom_addr_o<=0, go to FETCH.
  - start_i is ignored in every other state.
- FETCH: one cycle. The ROM samples rom_addr_o at the end of this cycle; go to DECODE.
- DECODE: rom_data_i is valid in this cycle.
  - dur=0 → end handling.
  - dur≠0 → note_o<=note, note_valid_o<=1, beat counter<=0, duration counter<=dur; go to PLAY.
- PLAY:
  - Beat counter counts 0..BEAT_DIV-1. On terminal count it clears and the duration counter decrements.
  - When the duration counter would reach 0: if rom_addr_o = 2^ADDR_WIDTH-1, take end handling; else rom_addr_o<=rom_addr_o+1 and go to FETCH.
  - Note length is therefore dur×BEAT_DIV cycles in PLAY, plus 2 cycles (FETCH+DECODE) before the next note.
  - note_o and note_valid_o hold their value through FETCH/DECODE until the next DECODE overwrites them.
- End handling (without loop feature): note_o<=0, note_valid_o<=0, done_o pulses 1 cycle, rom_addr_o<=0, go to IDLE.
- stop_i=1 in any state: next cycle IDLE, note_o=0, note_valid_o=0, rom_addr_o=0, counters 0, no done_o.
  - stop_i has priority over start_i and over any simultaneous end/transition event.
- busy_o is combinational from the state: busy_o=(state≠IDLE).
- rst_n asserted mid-song: immediate return to the reset values above; no done_o.
- No combinational path from start_i/stop_i to outputs other than busy_o (which follows state only).

Optional Feature:
- Macro: MUSIC_SEQ_LOOP_EN.
- Defined: end handling (dur=0 marker or last address) sets rom_addr_o<=0 and goes to FETCH instead of IDLE.
  - done_o still pulses 1 cycle per pass.
  - note_o/note_valid_o are cleared during the 2-cycle refetch.
  - busy_o stays 1; only stop_i or reset ends playback.
- Undefined: end handling returns to IDLE as specified.

Test Plan (BEAT_DIV=4, ADDR_WIDTH=4, behavioural ROM model with 1-cycle latency):
- Reset values: rst_n low with random inputs → all outputs 0; release rst_n, no start → remain IDLE.
- Basic song: ROM[0]=0x2_45, ROM[1]=0x1_30, ROM[2]=0x0_00; pulse start_i.
  - Required: note_o=0x45 for 8 PLAY cycles, then 0x30 for 4.
  - Required: done_o pulses once at end; busy_o drops the same cycle as return to IDLE; rom_addr_o returns to 0.
- Rest word: ROM[0]=0x3_00 → note_valid_o=1, note_o=0 for 12 cycles.
- Stop mid-note: stop_i at PLAY cycle 3 of note 0x45 → next cycle note_o=0, busy_o=0, no done_o. start_i and stop_i asserted together in IDLE → stays IDLE.
- Address wrap: all 16 words dur=1 and no marker → 16 notes played, then done_o at address 15. With MUSIC_SEQ_LOOP_EN, playback restarts at address 0 and done_o pulses every 16 notes.
- Async reset mid-PLAY: drop rst_n between clock edges → outputs clear immediately without a clock edge; start_i afterwards replays from address 0.

Source files
------------

// File: rtl/music_seq_ctrl.sv
// Song ROM sequencer: fetches {dur,note} words, holds each note for dur*BEAT_DIV clocks.
// Optional MUSIC_SEQ_LOOP_EN: end of song restarts from address 0 instead of returning idle.
module music_seq_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned BEAT_DIV   = 12500000,
  parameter int unsigned CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [7:0]            note_o,
  output logic                  note_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned DUR_WIDTH  = 4;
  localparam int unsigned NOTE_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0]  BEAT_LAST = CNT_WIDTH'(BEAT_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    PLAY   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_beat;
  logic [DUR_WIDTH-1:0]    r_dur;

  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   w_addr_next;
  logic [NOTE_WIDTH-1:0]   w_note_next;
  logic                    w_valid_next;
  logic                    w_done_next;
  logic [CNT_WIDTH-1:0]    w_beat_next;
  logic [DUR_WIDTH-1:0]    w_dur_next;
  logic                    w_end;
  logic [DUR_WIDTH-1:0]    w_rom_dur;
  logic [NOTE_WIDTH-1:0]   w_rom_note;

  assign w_rom_dur  = rom_data_i[11:8];
  assign w_rom_note = rom_data_i[7:0];
  assign busy_o     = (r_state != IDLE);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      rom_addr_o   <= '0;
      note_o       <= '0;
      note_valid_o <= 1'b0;
      done_o       <= 1'b0;
      r_beat       <= '0;
      r_dur        <= '0;
    end else begin
      r_state      <= w_state_next;
      rom_addr_o   <= w_addr_next;
      note_o       <= w_note_next;
      note_valid_o <= w_valid_next;
      done_o       <= w_done_next;
      r_beat       <= w_beat_next;
      r_dur        <= w_dur_next;
    end
  end

  // Next-state and next-output logic; stop overrides everything else
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = rom_addr_o;
    w_note_next  = note_o;
    w_valid_next = note_valid_o;
    w_done_next  = 1'b0;
    w_beat_next  = r_beat;
    w_dur_next   = r_dur;
    w_end        = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_addr_next  = '0;
          w_state_next = FETCH;
        end
      end
      FETCH: w_state_next = DECODE;
      DECODE: begin
        if (w_rom_dur == '0) begin
          w_end = 1'b1;
        end else begin
          w_note_next  = w_rom_note;
          w_valid_next = 1'b1;
          w_beat_next  = '0;
          w_dur_next   = w_rom_dur;
          w_state_next = PLAY;
        end
      end
      PLAY: begin
        if (r_beat == BEAT_LAST) begin
          w_beat_next = '0;
          w_dur_next  = r_dur - DUR_WIDTH'(1);
          if (r_dur == DUR_WIDTH'(1)) begin
            if (rom_addr_o == ADDR_LAST) begin
              w_end = 1'b1;
            end else begin
              w_addr_next  = rom_addr_o + ADDR_WIDTH'(1);
              w_state_next = FETCH;
            end
          end
        end else begin
          w_beat_next = r_beat + CNT_WIDTH'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_end) begin
      w_note_next  = '0;
      w_valid_next = 1'b0;
      w_done_next  = 1'b1;
      w_addr_next  = '0;
      w_beat_next  = '0;
      w_dur_next   = '0;
`ifdef MUSIC_SEQ_LOOP_EN
      w_state_next = FETCH;
`else
      w_state_next = IDLE;
`endif
    end

    if (stop_i) begin
      w_state_next = IDLE;
      w_addr_next  = '0;
      w_note_next  = '0;
      w_valid_next = 1'b0;
      w_done_next  = 1'b0;
      w_beat_next  = '0;
      w_dur_next   = '0;
    end
  end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Scoreboard bench for music_seq_ctrl: note segments (note, visible length) and done pulses.
module tb_music_seq_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 12;
  localparam int unsigned BD = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic [7:0]    note_o;
  logic          note_valid_o;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] rom [16];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_done;
    logic [7:0] note;
    int         len;
  } obs_t;
  obs_t exp_q[$];

  bit         m_pv = 1'b0;
  logic [7:0] m_pn = '0;
  int         m_len = 0;

  music_seq_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEAT_DIV(BD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .note_o(note_o),
    .note_valid_o(note_valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Behavioural ROM, one-cycle read latency
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic emit(input bit d, input logic [7:0] n, input int l);
    obs_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got done=%0d note=0x%0h len=%0d, required none", d, n, l);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 32'(d), 32'(e.is_done));
    if (!d && !e.is_done) begin
      chk("seg_note", 32'(n), 32'(e.note));
      chk("seg_len", 32'(l), 32'(e.len));
    end
  endtask

  // Monitor: turns output activity into segment/done observations
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pv  = 1'b0;
        m_len = 0;
      end else begin
        if (note_valid_o && m_pv && note_o == m_pn) begin
          m_len++;
        end else begin
          if (m_pv) emit(1'b0, m_pn, m_len);
          m_pv  = note_valid_o;
          m_pn  = note_o;
          m_len = note_valid_o ? 1 : 0;
        end
        if (done_o) begin
          emit(1'b1, 8'h00, 0);
          chk("done_busy", 32'(busy_o), 32'd0);
          chk("done_addr", 32'(rom_addr_o), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input logic [7:0] n, input int l);
    obs_t e;
    e.is_done = 1'b0;
    e.note    = n;
    e.len     = l;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    obs_t e;
    e.is_done = 1'b1;
    e.note    = 8'h00;
    e.len     = 0;
    exp_q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = '0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy_o && i < budget) begin
      tick();
      i++;
    end
    chk("idle_within_budget", 32'(busy_o), 32'd0);
    repeat (2) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(rom_addr_o),   32'd0);
    chk({tag, "_note"},  32'(note_o),       32'd0);
    chk({tag, "_valid"}, 32'(note_valid_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o),       32'd0);
    chk({tag, "_done"},  32'(done_o),       32'd0);
  endtask

  initial begin
    clear_rom();
    // Reset with random inputs
    start_i = 1'($urandom);
    stop_i  = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    start_i = 1'b0;
    stop_i  = 1'b0;
    rst_n   = 1'b1;
    repeat (4) tick();
    chk("idle_no_start", 32'(busy_o), 32'd0);

    // Basic song: 0x45 for 2 beats, 0x30 for 1 beat, then marker
    rom[0] = 12'h245;
    rom[1] = 12'h130;
    push_seg(8'h45, 2 * BD + 2);
    push_seg(8'h30, 1 * BD + 2);
    push_done();
    pulse_start();
    chk("busy_after_start", 32'(busy_o), 32'd1);
    wait_idle(200);
    chk("addr_after_song", 32'(rom_addr_o), 32'd0);

    // Rest word: valid note of code 0
    clear_rom();
    rom[0] = 12'h300;
    push_seg(8'h00, 3 * BD + 2);
    push_done();
    pulse_start();
    wait_idle(200);

    // Stop during PLAY cycle 3 of 0x45
    clear_rom();
    rom[0] = 12'h245;
    rom[1] = 12'h130;
    push_seg(8'h45, 3);
    pulse_start();
    repeat (4) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("stop_busy", 32'(busy_o), 32'd0);
    chk("stop_note", 32'(note_o), 32'd0);
    chk("stop_valid", 32'(note_valid_o), 32'd0);
    chk("stop_addr", 32'(rom_addr_o), 32'd0);
    repeat (4) tick();

    // start and stop together in IDLE
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("start_stop_busy", 32'(busy_o), 32'd0);
    tick();
    chk("start_stop_busy2", 32'(busy_o), 32'd0);

    // Address wrap: 16 one-beat notes, no marker; last address ends straight from PLAY
    for (int i = 0; i < 16; i++) rom[i] = {4'h1, 8'(8'h10 + i)};
    for (int i = 0; i < 15; i++) push_seg(8'(8'h10 + i), BD + 2);
    push_seg(8'h1F, BD);
    push_done();
    pulse_start();
    wait_idle(400);
    chk("addr_after_wrap", 32'(rom_addr_o), 32'd0);

    // Async reset mid-PLAY, then replay from address 0
    clear_rom();
    rom[0] = 12'h245;
    rom[1] = 12'h130;
    pulse_start();
    repeat (5) tick();
    chk("mid_play_valid", 32'(note_valid_o), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    push_seg(8'h45, 2 * BD + 2);
    push_seg(8'h30, 1 * BD + 2);
    push_done();
    pulse_start();
    wait_idle(200);

    repeat (5) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
